fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_seq_pkg.sv | 31 +++
 rtl/instr_decode.sv | 26 ++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, opcodes, default widths.
package fetch_seq_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefInstrW  = 16;
  localparam int unsigned DefTimeout = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StDecode,
    StUpdate,
    StHalt
  } state_e;

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpNor  = 4'b0011;
  localparam logic [3:0] OpShfl = 4'b1011;
  localparam logic [3:0] OpShfr = 4'b1100;
  localparam logic [3:0] OpJmp  = 4'b1000;
  localparam logic [3:0] OpBrz  = 4'b1001;
  localparam logic [3:0] OpHalt = 4'b1111;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpNor) || (op == OpShfl) || (op == OpShfr);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode of the latched instruction register.
module instr_decode
  import fetch_seq_pkg::*;
#(
  parameter int unsigned INSTR_W = DefInstrW
) (
  input  logic [INSTR_W-1:0] ir_i,
  output logic [3:0]         alu_op_o,
  output logic               is_jmp_o,
  output logic               is_brz_o,
  output logic               is_halt_o
);

  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = ir_i[15:12];
  assign unused_ir = ^ir_i[11:0];

  // Non-ALU and undefined opcodes present a NOP to the ALU.
  assign alu_op_o  = is_alu_op(opcode) ? opcode : OpNop;
  assign is_jmp_o  = (opcode == OpJmp);
  assign is_brz_o  = (opcode == OpBrz);
  assign is_halt_o = (opcode == OpHalt);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/PC-update sequencer.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned INSTR_W = DefInstrW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  count,
  output logic               LoadPC,
  output logic               IncPC,
  output logic [ADDR_W-1:0]  new_count,
  output logic               instr_req,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_rdata,
  input  logic               zero_flag,
  input  logic               stall,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         alu_op,
  output logic               ir_valid,
  output logic               halted,
  output logic               fault
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               is_jmp, is_brz, is_halt;
  logic               take_load;
  logic               tmo_hit;

  instr_decode #(
    .INSTR_W (INSTR_W)
  ) u_instr_decode (
    .ir_i      (ir_q),
    .alu_op_o  (alu_op),
    .is_jmp_o  (is_jmp),
    .is_brz_o  (is_brz),
    .is_halt_o (is_halt)
  );

  assign take_load = is_jmp | (is_brz & zero_flag);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            fault_q, fault_d;

  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = '0;
    fault_d   = fault_q;
    if (state_q == StWait && !instr_valid) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      if (tmo_hit) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign fault          = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    addr_d     = addr_q;
    instr_req  = 1'b0;
    instr_addr = '0;
    ir_valid   = 1'b0;
    LoadPC     = 1'b0;
    IncPC      = 1'b0;
    new_count  = '0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        instr_req  = 1'b1;
        instr_addr = count;
        addr_d     = count;
        state_d    = StWait;
      end
      StWait: begin
        instr_req  = 1'b1;
        instr_addr = addr_q;
        if (instr_valid) begin
          ir_d    = instr_rdata;
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StHalt;
        end
      end
      StDecode: begin
        ir_valid = 1'b1;
        state_d  = is_halt ? StHalt : StUpdate;
      end
      StUpdate: begin
        // Strobes are masked while reset is low so a reset cycle never moves the PC.
        if (!stall) begin
          state_d = StFetch;
          if (reset) begin
            if (take_load) begin
              LoadPC    = 1'b1;
              new_count = ADDR_W'(ir_q[7:0]);
            end else begin
              IncPC = 1'b1;
            end
          end
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
    end
  end

  assign ir     = ir_q;
  assign halted = (state_q == StHalt);

endmodule
